// File: rtl/io_pkg.sv
// Shared definitions for the I/O handshake block: FSM state encoding and
// the board-level default debounce interval.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        ACK          = 3'd3,
        WAIT_DROP    = 3'd4
    } io_state_t;

    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/io_handshake_if.sv
// Control-unit side of the I/O handshake: instruction requests, data words
// and the completion/busy status returned by the handshake block.
interface io_handshake_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  is_input;
    logic                  is_output;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  confirmation;
    logic                  busy;
    logic [DATA_WIDTH-1:0] input_data;

    modport master (
        output is_input,
        output is_output,
        output output_data,
        input  confirmation,
        input  busy,
        input  input_data
    );

    modport slave (
        input  is_input,
        input  is_output,
        input  output_data,
        output confirmation,
        output busy,
        output input_data
    );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for the board push-button;
// emits the accepted level and one-cycle press/release pulses.
module button_debouncer
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync     <= '0;
            level    <= 1'b0;
            cnt      <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync     <= {sync[0], raw};
            pressed  <= 1'b0;
            released <= 1'b0;
            // The sample that completes the run flips the level directly,
            // so a change needs exactly DEBOUNCE_CYCLES disagreeing samples.
            if (sync[1] != level) begin
                if (cnt == LAST) begin
                    level    <= sync[1];
                    cnt      <= '0;
                    pressed  <= sync[1];
                    released <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/io_handshake.sv
// Button-paced I/O handshake between the control unit and the board:
// captures switches / latches display data, confirms on a debounced press+release.
module io_handshake
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SWITCH_WIDTH    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    io_handshake_if.slave           cu,
    input  logic                    continue_raw,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic [DATA_WIDTH-1:0]   display_data,
    output logic                    display_valid
);

    io_state_t             state;
    logic                  confirmation_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] input_data_q;
    logic                  btn_level;
    logic                  btn_pressed;
    logic                  btn_released;
    logic                  request;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .raw     (continue_raw),
        .level   (btn_level),
        .pressed (btn_pressed),
        .released(btn_released)
    );

    assign request = cu.is_input | cu.is_output;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            confirmation_q <= 1'b0;
            busy_q         <= 1'b0;
            input_data_q   <= '0;
            display_data   <= '0;
            display_valid  <= 1'b0;
        end else begin
            confirmation_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (request) begin
                        state  <= WAIT_PRESS;
                        busy_q <= 1'b1;
                        if (cu.is_output) begin
                            display_data  <= cu.output_data;
                            display_valid <= 1'b1;
                        end
                    end
                end
                // Only edges count, so a button already held at request time
                // must be released and pressed again.
                WAIT_PRESS: begin
                    if (!request) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (btn_pressed && btn_level) begin
                        state <= WAIT_RELEASE;
                        if (cu.is_input)
                            input_data_q <= DATA_WIDTH'(switches);
                    end
                end
                WAIT_RELEASE: begin
                    if (!request) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (btn_released && !btn_level) begin
                        state          <= ACK;
                        confirmation_q <= 1'b1;
                    end
                end
                ACK: begin
                    state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!request) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign cu.confirmation = confirmation_q;
    assign cu.busy         = busy_q;
    assign cu.input_data   = input_data_q;

endmodule
